// File: rtl/bhr_controller.sv
// bhr_controller: speculative / architectural global branch history manager.
// Keeps a small FIFO of predicted directions for in-flight conditional
// branches, maintains a speculative history updated at predict time and an
// architectural history updated at resolve time, and repairs the speculative
// history from the architectural one on a mispredict or pipeline flush.
module bhr_controller #(
  parameter int HIST_W = 8,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [31:0]              pred_pc,
  output logic                     pred_ready,
  output logic [IDX_W-1:0]         pht_idx,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic                     flush,
  output logic                     mispredict,
  output logic [HIST_W-1:0]        spec_hist,
  output logic [HIST_W-1:0]        arch_hist,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t            r_state;
  logic [DEPTH-1:0]  r_fifo;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [HIST_W-1:0] r_spec_hist;
  logic [HIST_W-1:0] r_arch_hist;
  logic              r_err_underflow;

  logic              w_empty;
  logic              w_pred_acc;
  logic              w_res_acc;
  logic              w_head;
  logic              w_mispredict;
  logic              w_kill;
  logic              w_push;
  logic [HIST_W-1:0] w_arch_next;

  // Handshake and resolve qualification. A full queue never admits a new
  // prediction, even when the oldest entry is popped in the same cycle.
  assign w_empty      = (r_count == '0);
  assign pred_ready   = (r_state == ST_RUN) && (r_count < FULL_CNT);
  assign w_pred_acc   = pred_valid && pred_ready;
  assign w_res_acc    = res_valid && !w_empty;
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_mispredict = w_res_acc && (res_taken != w_head);
  // Any recovery event discards the queue and any same-cycle prediction.
  assign w_kill       = w_mispredict || flush;
  assign w_push       = w_pred_acc && !w_kill;

  // Committed history including this cycle's resolve; used both as the next
  // arch_hist and as the repair value for spec_hist.
  assign w_arch_next = w_res_acc ? {r_arch_hist[HIST_W-2:0], res_taken} : r_arch_hist;

  // gshare index folds the word-aligned PC with the speculative history.
  assign pht_idx = pred_pc[IDX_W+1:2] ^ r_spec_hist[IDX_W-1:0];

  assign mispredict    = w_mispredict;
  assign spec_hist     = r_spec_hist;
  assign arch_hist     = r_arch_hist;
  assign inflight      = r_count;
  assign err_underflow = r_err_underflow;

  // Direction storage for in-flight branches.
  // NOTE: the FIFO data has no reset; entries are only read when the count
  // says they were written, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= pred_taken;
    end
  end

  // Recovery state machine: one RECOVER cycle after every mispredict/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:     if (w_kill) r_state <= ST_RECOVER;
        ST_RECOVER: r_state <= ST_RUN;
        default:    r_state <= ST_RUN;
      endcase
    end
  end

  // Histories, queue pointers/occupancy and the sticky underflow flag.
  // NOTE: every register here is written with <= so all of them sample the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec_hist     <= '0;
      r_arch_hist     <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_arch_hist <= w_arch_next;
      if (res_valid && w_empty) begin
        r_err_underflow <= 1'b1;
      end
      if (w_kill) begin
        r_spec_hist <= w_arch_next;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
      end else begin
        if (w_push) begin
          r_spec_hist <= {r_spec_hist[HIST_W-2:0], pred_taken};
          r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
        end
        if (w_res_acc) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_res_acc})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: doc/bhr_controller.md
BHR_CONTROLLER -- requirements
Module: bhr_controller

Interface
REQ-001 SHALL have parameter HIST_W, default 8: global history width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: maximum in-flight unresolved branches (power of 2).
REQ-003 SHALL have parameter IDX_W, default 8: PHT index width, IDX_W <= HIST_W.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pred_valid  input  1  fetch presents a predicted conditional branch.
REQ-007 SHALL have port pred_taken  input  1  predicted direction.
REQ-008 SHALL have port pred_pc  input  32  branch PC.
REQ-009 SHALL have port pred_ready  output  1  prediction accepted when pred_valid & pred_ready.
REQ-010 SHALL have port pht_idx  output  IDX_W  gshare index = pred_pc[IDX_W+1:2] XOR spec_hist[IDX_W-1:0], combinational.
REQ-011 SHALL have port res_valid  input  1  oldest in-flight branch resolves this cycle.
REQ-012 SHALL have port res_taken  input  1  actual direction of resolving branch.
REQ-013 SHALL have port flush  input  1  non-branch pipeline flush (exception/trap).
REQ-014 SHALL have port mispredict  output  1  combinational pulse: accepted resolve disagrees with stored prediction.
REQ-015 SHALL have port spec_hist  output  HIST_W  speculative history register.
REQ-016 SHALL have port arch_hist  output  HIST_W  committed history register.
REQ-017 SHALL have port inflight  output  $clog2(DEPTH)+1  occupied queue entries.
REQ-018 SHALL have port err_underflow  output  1  sticky: res_valid seen with empty queue.

Function
REQ-019 SHALL hold a DEPTH-entry FIFO of predicted-direction bits; push on accepted prediction, pop on accepted resolve.
REQ-020 SHALL assert pred_ready iff state==RUN and inflight<DEPTH; no full-queue bypass even with a simultaneous resolve.
REQ-021 On accepted prediction SHALL shift spec_hist <= {spec_hist[HIST_W-2:0], pred_taken}, one-cycle latency.
REQ-022 An accepted resolve requires res_valid and inflight>0; it SHALL shift arch_hist <= {arch_hist[HIST_W-2:0], res_taken}.
REQ-023 mispredict SHALL equal accepted_resolve & (res_taken != FIFO head bit).
REQ-024 On mispredict SHALL set spec_hist <= updated arch_hist, clear FIFO (inflight <= 0), drop any same-cycle prediction, enter RECOVER.
REQ-025 State machine: RUN -> RECOVER on mispredict or flush; RECOVER -> RUN unconditionally after exactly one cycle; pred_ready=0 in RECOVER.
REQ-026 In RECOVER SHALL ignore pred_valid; res_valid with empty queue still sets err_underflow.
REQ-027 flush SHALL set spec_hist <= arch_hist (including any same-cycle accepted resolve), clear FIFO, drop same-cycle prediction, enter RECOVER.
REQ-028 flush together with mispredict SHALL behave identically to mispredict alone; mispredict output still pulses.
REQ-029 Simultaneous accepted prediction and correct resolve SHALL push and pop; inflight unchanged; spec_hist shifts, arch_hist shifts.
REQ-030 res_valid with inflight==0 SHALL be ignored (no shift, no mispredict) and set err_underflow until reset.
REQ-031 FIFO read/write pointers SHALL wrap modulo DEPTH; inflight SHALL never exceed DEPTH or underflow.

Reset
REQ-032 While rst_n=0, asynchronously: spec_hist=0, arch_hist=0, inflight=0, pointers=0, state=RUN, err_underflow=0.
REQ-033 Out of reset SHALL present pred_ready=1, mispredict=0; reset deassertion mid-operation discards all in-flight branches.

Verification
REQ-034 Predict T,T,N (pred_pc=0x40) from reset -> spec_hist=0x06, arch_hist=0x00, inflight=3; pht_idx at third predict = 0x10^0x03=0x13.
REQ-035 Fill 4 predictions, assert 5th pred_valid -> pred_ready=0, inflight stays 4; same cycle resolve correct -> inflight=3, 5th accepted next cycle.
REQ-036 Predict T,T,T then resolve first with res_taken=0 -> mispredict=1 that cycle, arch_hist=0x00, spec_hist=0x00, inflight=0, pred_ready=0 one cycle then 1.
REQ-037 Predict T,N then flush with correct resolve of first -> arch_hist=0x01, spec_hist=0x01, inflight=0, RECOVER one cycle.
REQ-038 res_valid with empty queue -> no history change, mispredict=0, err_underflow=1 until rst_n=0.
REQ-039 Assert rst_n=0 mid-cycle with inflight=2 -> all outputs reset immediately without clock edge.
